// File: rtl/regfile_writeback_sink.sv
// Integer register file fed by the writeback write bus: two combinational read
// ports with optional same-cycle forwarding, a debug read port and a commit counter.
module regfile_writeback_sink #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned BYPASS_EN = 1,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   output logic [XLEN-1:0]  rd1_d,
   output logic [XLEN-1:0]  rd2_d,
   input  logic [4:0]       rd_w,
   input  logic             reg_write_w,
   input  logic [XLEN-1:0]  result_w,
   input  logic [4:0]       dbg_addr,
   output logic [XLEN-1:0]  dbg_data,
   output logic [CNT_W-1:0] wr_count
);

   // x0 has no storage; the array starts at index 1
   logic [XLEN-1:0]  regs_q [1:REG_COUNT-1];
   logic [XLEN-1:0]  regs_d [1:REG_COUNT-1];
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             wr_en;
   logic             byp1;
   logic             byp2;

   // Qualifying with reg_write_w keeps an idle, possibly-X bus out of the state and muxes
   assign wr_en = reg_write_w && (rd_w != '0);
   assign byp1  = (BYPASS_EN != 0) && reg_write_w && (rd_w == rs1_d);
   assign byp2  = (BYPASS_EN != 0) && reg_write_w && (rd_w == rs2_d);

   always_comb begin
      regs_d = regs_q;
      cnt_d  = cnt_q;
      if (wr_en) begin
         regs_d[rd_w] = result_w;
         cnt_d        = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end

   // Read muxes; the debug port never sees the forward path
   always_comb begin
      rd1_d    = '0;
      rd2_d    = '0;
      dbg_data = '0;
      if (rs1_d != '0) begin
         rd1_d = byp1 ? result_w : regs_q[rs1_d];
      end
      if (rs2_d != '0) begin
         rd2_d = byp2 ? result_w : regs_q[rs2_d];
      end
      if (dbg_addr != '0) begin
         dbg_data = regs_q[dbg_addr];
      end
   end

   assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile_writeback_sink.sv
// Scoreboard bench: a forwarding/32-bit-counter instance and a no-forward/4-bit-counter
// instance share one stimulus stream; expected values are hand-computed per cycle.
module tb_regfile_writeback_sink;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_d, rs2_d, rd_w, dbg_addr;
   logic        reg_write_w;
   logic [31:0] result_w;
   logic [31:0] rd1_a, rd2_a, dbg_a, cnt_a;
   logic [31:0] rd1_b, rd2_b, dbg_b;
   logic [3:0]  cnt_b;

   always #5 clk = ~clk;

   regfile_writeback_sink #(.XLEN(32), .REG_COUNT(32), .BYPASS_EN(1), .CNT_W(32)) u_byp (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd1_d(rd1_a), .rd2_d(rd2_a),
      .rd_w(rd_w), .reg_write_w(reg_write_w), .result_w(result_w),
      .dbg_addr(dbg_addr), .dbg_data(dbg_a), .wr_count(cnt_a));

   regfile_writeback_sink #(.XLEN(32), .REG_COUNT(32), .BYPASS_EN(0), .CNT_W(4)) u_nobyp (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd1_d(rd1_b), .rd2_d(rd2_b),
      .rd_w(rd_w), .reg_write_w(reg_write_w), .result_w(result_w),
      .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_count(cnt_b));

   typedef struct {
      string       name;
      logic [31:0] rd1, rd2, dbg, cnt, rd1nb, rd2nb;
      logic [3:0]  cnt4;
      logic [7:0]  mask;
   } exp_t;

   // mask bits: 0 rd1, 1 rd2, 2 dbg (both), 3 cnt, 4 rd1 no-fwd, 5 rd2 no-fwd, 6 cnt4
   localparam logic [7:0] M_ALL  = 8'h7F;
   localparam logic [7:0] M_CNT  = 8'h48;
   localparam logic [7:0] M_NONE = 8'h00;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input string field, input logic [31:0] act,
                      input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s.%s: got %h expected %h", nm, field, act, expv);
      end
   endtask

   // Monitor: outputs are combinational, so every cycle presents a sample mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         if (e.mask[0]) chk(e.name, "rd1",      rd1_a,        e.rd1);
         if (e.mask[1]) chk(e.name, "rd2",      rd2_a,        e.rd2);
         if (e.mask[2]) chk(e.name, "dbg",      dbg_a,        e.dbg);
         if (e.mask[2]) chk(e.name, "dbg_nf",   dbg_b,        e.dbg);
         if (e.mask[3]) chk(e.name, "cnt",      cnt_a,        e.cnt);
         if (e.mask[4]) chk(e.name, "rd1_nf",   rd1_b,        e.rd1nb);
         if (e.mask[5]) chk(e.name, "rd2_nf",   rd2_b,        e.rd2nb);
         if (e.mask[6]) chk(e.name, "cnt4",     32'(cnt_b),   32'(e.cnt4));
      end
   end

   task automatic step(input string nm, input logic r, input logic we, input logic [4:0] rd,
                       input logic [31:0] res, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] ad, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] ed, input logic [31:0] ec, input logic [31:0] e1n,
                       input logic [31:0] e2n, input logic [3:0] ec4, input logic [7:0] m);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; reg_write_w = we; rd_w = rd; result_w = res;
      rs1_d = a1; rs2_d = a2; dbg_addr = ad;
      e.name = nm; e.rd1 = e1; e.rd2 = e2; e.dbg = ed; e.cnt = ec;
      e.rd1nb = e1n; e.rd2nb = e2n; e.cnt4 = ec4; e.mask = m;
      q.push_back(e);
   endtask

   initial begin
      rst = 1'b1; reg_write_w = 1'b0; rd_w = '0; result_w = '0;
      rs1_d = '0; rs2_d = '0; dbg_addr = '0;

      //    name          rst we rd  result        rs1 rs2 dbg  rd1           rd2           dbg           cnt rd1nb         rd2nb        cnt4 mask
      step("rst",         1, 0, 0,  32'h0,        0,  0,  0,   32'h0,        32'h0,        32'h0,        0,  32'h0,        32'h0,        0, M_NONE);
      step("reset_state", 0, 0, 0,  32'h0,        5,  6,  7,   32'h0,        32'h0,        32'h0,        0,  32'h0,        32'h0,        0, M_ALL);
      step("pre_x5",      0, 1, 5,  32'hDEADBEEF, 5,  5,  5,   32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0,  32'h0,        32'h0,        0, M_ALL);
      step("pre_chk",     0, 0, 0,  32'h0,        5,  0,  5,   32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1,  32'hDEADBEEF, 32'h0,        1, M_ALL);
      step("rst_wr",      1, 1, 6,  32'h1234,     5,  6,  5,   32'hDEADBEEF, 32'h1234,     32'hDEADBEEF, 1,  32'hDEADBEEF, 32'h0,        1, M_ALL);
      step("rst_clr",     0, 0, 0,  32'h0,        5,  6,  6,   32'h0,        32'h0,        32'h0,        0,  32'h0,        32'h0,        0, M_ALL);
      step("wr_x10",      0, 1, 10, 32'hA5,       0,  0,  0,   32'h0,        32'h0,        32'h0,        0,  32'h0,        32'h0,        0, M_ALL);
      step("rd_x10",      0, 0, 0,  32'h0,        10, 10, 10,  32'hA5,       32'hA5,       32'hA5,       1,  32'hA5,       32'hA5,       1, M_ALL);
      step("wr_x3",       0, 1, 3,  32'h11,       10, 3,  3,   32'hA5,       32'h11,       32'h0,        1,  32'hA5,       32'h0,        1, M_ALL);
      step("byp_x3",      0, 1, 3,  32'h22,       3,  10, 3,   32'h22,       32'hA5,       32'h11,       2,  32'h11,       32'hA5,       2, M_ALL);
      step("dbg_x3",      0, 0, 0,  32'h0,        3,  3,  3,   32'h22,       32'h22,       32'h22,       3,  32'h22,       32'h22,       3, M_ALL);
      step("x0_wr",       0, 1, 0,  32'hFFFFFFFF, 0,  3,  0,   32'h0,        32'h22,       32'h0,        3,  32'h0,        32'h22,       3, M_ALL);
      step("x0_after",    0, 0, 0,  32'h0,        0,  0,  0,   32'h0,        32'h0,        32'h0,        3,  32'h0,        32'h0,        3, M_ALL);
      step("wr_x7",       0, 1, 7,  32'h7,        0,  0,  0,   32'h0,        32'h0,        32'h0,        3,  32'h0,        32'h0,        3, M_ALL);
      step("wr_x8",       0, 1, 8,  32'h8,        7,  7,  7,   32'h7,        32'h7,        32'h7,        4,  32'h7,        32'h7,        4, M_ALL);
      step("dual",        0, 1, 8,  32'h80,       7,  8,  8,   32'h7,        32'h80,       32'h8,        5,  32'h7,        32'h8,        5, M_ALL);
      step("dual_after",  0, 0, 0,  32'h0,        8,  7,  8,   32'h80,       32'h7,        32'h80,       6,  32'h80,       32'h7,        6, M_ALL);
      step("x_safe",      0, 0, 'x, 'x,           8,  3,  3,   32'h80,       32'h22,       32'h22,       6,  32'h80,       32'h22,       6, M_ALL);
      step("rst2",        1, 0, 0,  32'h0,        0,  0,  0,   32'h0,        32'h0,        32'h0,        6,  32'h0,        32'h0,        6, M_CNT);

      // 17 commits after reset with idle cycles in between; the 4-bit counter wraps to 1
      for (int k = 0; k < 17; k++) begin
         step("wrap_wr", 0, 1, 5'(k + 1), 32'h100 + 32'(k), 0, 5'(k + 1), 0,
              32'h0, 32'h100 + 32'(k), 32'h0, 32'(k), 32'h0, 32'h0, 4'(k), M_ALL);
         if (k % 2 == 1)
            step("wrap_idle", 0, 0, 0, 32'h0, 0, 0, 0,
                 32'h0, 32'h0, 32'h0, 32'(k + 1), 32'h0, 32'h0, 4'(k + 1), M_ALL);
      end
      step("wrap_end",    0, 0, 0,  32'h0,        17, 1,  9,   32'h110,      32'h100,      32'h108,      17, 32'h110,      32'h100,      1, M_ALL);

      repeat (2) @(posedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_writeback_sink.md
Name: regfile_writeback_sink

Overview:
- Integer register file; consumes the writeback-stage write bus (rd_w / reg_write_w / result_w) driven by the pipeline.
- Supplies decode-stage operands on two combinational read ports, with same-cycle write-through bypass.
- Architectural x0 is hardwired to zero.
- Includes a retired-write counter and a debug read port for bench and trace observation.

Parameters:
- XLEN, 32, data width of every register and result bus.
- REG_COUNT, 32, number of architectural registers; index width is fixed at 5 bits.
- BYPASS_EN, 1, 1 = same-cycle write data forwarded to read ports; 0 = read ports return stored value only.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; sampled only on posedge clk.
- rs1_d  input  5  read port 1 address (decode stage).
- rs2_d  input  5  read port 2 address.
- rd1_d  output  XLEN  read port 1 data (combinational).
- rd2_d  output  XLEN  read port 2 data (combinational).
- rd_w  input  5  write address from writeback stage.
- reg_write_w  input  1  write enable from writeback stage.
- result_w  input  XLEN  write data from writeback stage.
- dbg_addr  input  5  debug read address.
- dbg_data  output  XLEN  debug read data; stored value only, never bypassed.
- wr_count  output  CNT_W  number of committed non-x0 writes since reset.

Behaviour:
- Storage:
  - Entries 1..31 are XLEN-bit flops.
  - Entry 0 is not stored; reads of index 0 return 0 on every port regardless of writes.
- Reset (rst=1 at posedge clk):
  - All entries 1..31 are set to 0 and wr_count is set to 0.
  - Reset has priority over a simultaneous write: the write is dropped and wr_count does not increment.
  - Outputs are combinational from stored state, so rd1_d, rd2_d and dbg_data read 0 from the cycle after the reset edge. During the reset-asserted cycle the ports still read pre-reset contents, plus bypass if enabled.
- Write (rst=0, reg_write_w=1, rd_w!=0 at posedge clk):
  - regs[rd_w] <= result_w.
  - wr_count <= wr_count + 1, wrapping modulo 2^CNT_W.
  - Writes with rd_w=0 are discarded and do not count.
  - reg_write_w=0 means no state change.
- Read ports 1 and 2 are independent and identical:
  - If rs=0, output 0.
  - Else if BYPASS_EN=1, reg_write_w=1 and rd_w=rs, output result_w (same-cycle forward).
  - Else output regs[rs].
  - Both ports may address the same register, or the register being written, in the same cycle; each resolves independently.
- Latency:
  - Reads have 0 cycles of latency.
  - A write becomes visible in stored state 1 cycle after the edge; with BYPASS_EN=1 it is visible to rd1_d/rd2_d in the write cycle.
- dbg_data:
  - Returns regs[dbg_addr] (0 for index 0).
  - Reflects a write only after the committing edge.
- X-safety: rd_w, result_w and rs* may be X when reg_write_w=0. Outputs must not go X from an unused bypass path, i.e. the mux select is qualified by reg_write_w.
- No stalls and no handshakes: every write presented is committed on the next edge unless rst=1.

Test Plan:
- Reset clear: preload x5=0xDEADBEEF, assert rst 1 cycle with reg_write_w=1, rd_w=6, result_w=0x1234 -> after edge, x5=0, x6=0, wr_count=0.
- Basic write/read: write x10=0x0000_00A5, next cycle rs1_d=10, rs2_d=10 -> rd1_d=rd2_d=0x000000A5; dbg_addr=10 -> dbg_data=0xA5; wr_count=1.
- Bypass: x3 holds 0x11; same cycle reg_write_w=1, rd_w=3, result_w=0x22, rs1_d=3, dbg_addr=3 -> rd1_d=0x22, dbg_data=0x11. Next cycle dbg_data=0x22. With BYPASS_EN=0, rd1_d=0x11 in the write cycle.
- x0 hardwire: write rd_w=0, result_w=0xFFFFFFFF -> rd1_d (rs1_d=0)=0 in the same and next cycle; wr_count unchanged.
- Dual-port independence: x7=0x7, x8=0x8; write x8=0x80 while rs1_d=7, rs2_d=8 -> rd1_d=0x7, rd2_d=0x80.
- Counter wrap: with CNT_W=4, perform 17 non-x0 writes after reset -> wr_count=1; interleaved reg_write_w=0 cycles do not increment.
